// File: rtl/div_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_ctrl : glitch-safe reprogramming sequencer for the odd/even clock dividers
// Revision : 1.0
// ---------------------------------------------------------------------------
module div_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DRAIN_CYC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_div,
  output logic             req_ready,
  output logic [WIDTH-1:0] div_n,
  output logic             div_rst,
  output logic             odd_en,
  output logic             even_en,
  output logic             bypass,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic [WIDTH-1:0] cur_div
);

  localparam int CNT_W = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   lat_q, lat_d;
  logic [WIDTH-1:0]   div_n_q, div_n_d;
  logic [WIDTH-1:0]   cur_div_q, cur_div_d;
  logic               div_rst_q, div_rst_d;
  logic               odd_en_q, odd_en_d;
  logic               even_en_q, even_en_d;
  logic               bypass_q, bypass_d;
  logic               cfg_done_q, cfg_done_d;
  logic               cfg_err_q, cfg_err_d;
  logic               req_ready_q, req_ready_d;

  logic               accept;
  logic               lat_bypass;
  logic               lat_odd;
  logic               lat_even;

  assign accept     = req_valid & req_ready_q;
  assign lat_bypass = (lat_q == WIDTH'(1));
  assign lat_odd    = lat_q[0] & ~lat_bypass;
  assign lat_even   = ~lat_q[0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_d       = lat_q;
    div_n_d     = div_n_q;
    cur_div_d   = cur_div_q;
    odd_en_d    = odd_en_q;
    even_en_d   = even_en_q;
    bypass_d    = bypass_q;
    div_rst_d   = 1'b0;
    cfg_done_d  = 1'b0;
    cfg_err_d   = 1'b0;

    case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          if (req_div == '0) begin
            cfg_err_d = 1'b1;
          end else if ((state_q == RUN) && (req_div == cur_div_q)) begin
            cfg_done_d = 1'b1;
          end else begin
            // Enables drop first so the dividers stop before N changes
            state_d   = DRAIN;
            cnt_d     = CNT_W'(DRAIN_CYC);
            lat_d     = req_div;
            odd_en_d  = 1'b0;
            even_en_d = 1'b0;
            bypass_d  = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d   = LOAD;
          div_rst_d = 1'b1;
          cur_div_d = lat_q;
          if (lat_bypass)   div_n_d = WIDTH'(1);
          else if (lat_odd) div_n_d = lat_q;
          else              div_n_d = lat_q >> 1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LOAD: begin
        state_d    = RUN;
        odd_en_d   = lat_odd;
        even_en_d  = lat_even;
        bypass_d   = lat_bypass;
        cfg_done_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE) || (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lat_q       <= '0;
      div_n_q     <= '0;
      cur_div_q   <= '0;
      div_rst_q   <= 1'b0;
      odd_en_q    <= 1'b0;
      even_en_q   <= 1'b0;
      bypass_q    <= 1'b0;
      cfg_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      div_n_q     <= div_n_d;
      cur_div_q   <= cur_div_d;
      div_rst_q   <= div_rst_d;
      odd_en_q    <= odd_en_d;
      even_en_q   <= even_en_d;
      bypass_q    <= bypass_d;
      cfg_done_q  <= cfg_done_d;
      cfg_err_q   <= cfg_err_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready = req_ready_q;
  assign div_n     = div_n_q;
  assign div_rst   = div_rst_q;
  assign odd_en    = odd_en_q;
  assign even_en   = even_en_q;
  assign bypass    = bypass_q;
  assign cfg_done  = cfg_done_q;
  assign cfg_err   = cfg_err_q;
  assign cur_div   = cur_div_q;

  // Output mux selects must never overlap, nor be live while N is changing
  a_sel_onehot0 : assert property (@(posedge clk) disable iff (reset)
    $onehot0({odd_en_q, even_en_q, bypass_q}));
  a_sel_quiet : assert property (@(posedge clk) disable iff (reset)
    ((state_q == DRAIN) || (state_q == LOAD)) |-> !(odd_en_q | even_en_q | bypass_q));

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_div_ctrl : directed self-checking bench for div_ctrl
// Revision    : 1.0
// ---------------------------------------------------------------------------
module tb_div_ctrl;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic [7:0] req_div;
  logic       req_ready;
  logic [7:0] div_n;
  logic       div_rst;
  logic       odd_en;
  logic       even_en;
  logic       bypass;
  logic       cfg_done;
  logic       cfg_err;
  logic [7:0] cur_div;

  int n_checks = 0;
  int n_errors = 0;

  div_ctrl #(.WIDTH(8), .DRAIN_CYC(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_div   (req_div),
    .req_ready (req_ready),
    .div_n     (div_n),
    .div_rst   (div_rst),
    .odd_en    (odd_en),
    .even_en   (even_en),
    .bypass    (bypass),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .cur_div   (cur_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {req_ready, div_rst, odd_en, even_en, bypass, cfg_done, cfg_err}
  function automatic logic [6:0] flags();
    return {req_ready, div_rst, odd_en, even_en, bypass, cfg_done, cfg_err};
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Offers v for one edge; returns in cycle T+1 with valid low
  task automatic send(input logic [7:0] v);
    req_valid = 1'b1;
    req_div   = v;
    step(1);
    req_valid = 1'b0;
  endtask

  // Full reprogram of an odd value from IDLE/RUN; ends in first RUN cycle
  task automatic program_odd(input string tag, input logic [7:0] v);
    send(v);
    step(4);
    check({tag, "_load_n"}, div_n, v);
    step(1);
    check({tag, "_run_flags"}, flags(), 7'b1_0_1_0_0_1_0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_div   = 8'd0;
    step(2);
    check("rst_flags", flags(), 7'b0);
    check("rst_div_n", div_n, 8'd0);
    check("rst_cur_div", cur_div, 8'd0);
    reset = 1'b0;
    check("rel_ready_lo", req_ready, 1'b0);
    step(1);
    check("rel_ready_hi", req_ready, 1'b1);

    // req 7 from IDLE
    send(8'd7);
    check("r7_t1_flags", flags(), 7'b0);
    check("r7_t1_div_n", div_n, 8'd0);
    step(3);
    check("r7_t4_flags", flags(), 7'b0);
    step(1);
    check("r7_load_flags", flags(), 7'b0_1_0_0_0_0_0);
    check("r7_load_div_n", div_n, 8'd7);
    check("r7_load_cur", cur_div, 8'd7);
    step(1);
    check("r7_run_flags", flags(), 7'b1_0_1_0_0_1_0);
    step(1);
    check("r7_run2_flags", flags(), 7'b1_0_1_0_0_0_0);

    // RUN(7) -> req 10 (even, N=5)
    send(8'd10);
    check("r10_t1_flags", flags(), 7'b0);
    check("r10_t1_div_n", div_n, 8'd7);
    check("r10_t1_cur", cur_div, 8'd7);
    step(4);
    check("r10_load_flags", flags(), 7'b0_1_0_0_0_0_0);
    check("r10_load_div_n", div_n, 8'd5);
    check("r10_load_cur", cur_div, 8'd10);
    step(1);
    check("r10_run_flags", flags(), 7'b1_0_0_1_0_1_0);

    // req 1 -> bypass
    send(8'd1);
    step(4);
    check("r1_load_div_n", div_n, 8'd1);
    step(1);
    check("r1_run_flags", flags(), 7'b1_0_0_0_1_1_0);
    check("r1_cur", cur_div, 8'd1);

    // req 0 -> error pulse, nothing else moves
    send(8'd0);
    check("r0_t1_flags", flags(), 7'b1_0_0_0_1_0_1);
    check("r0_t1_div_n", div_n, 8'd1);
    check("r0_t1_cur", cur_div, 8'd1);
    step(1);
    check("r0_t2_flags", flags(), 7'b1_0_0_0_1_0_0);

    // RUN(7) then same value again -> done pulse only
    program_odd("p7", 8'd7);
    step(1);
    send(8'd7);
    check("same_t1_flags", flags(), 7'b1_0_1_0_0_1_0);
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("same_hold_flags", flags(), 7'b1_0_1_0_0_0_0);
    end
    check("same_div_n", div_n, 8'd7);

    // req 12 held valid; changed to 9 after accept; 9 accepted only in RUN
    req_valid = 1'b1;
    req_div   = 8'd12;
    step(1);
    req_div = 8'd9;
    check("hold_t1_ready", req_ready, 1'b0);
    step(3);
    check("hold_t4_ready", req_ready, 1'b0);
    step(1);
    check("hold_load_div_n", div_n, 8'd6);
    check("hold_load_cur", cur_div, 8'd12);
    check("hold_load_ready", req_ready, 1'b0);
    step(1);
    check("hold_run_flags", flags(), 7'b1_0_0_1_0_1_0);
    step(1);
    req_valid = 1'b0;
    check("hold2_t1_flags", flags(), 7'b0);
    step(4);
    check("hold2_load_div_n", div_n, 8'd9);
    step(1);
    check("hold2_run_flags", flags(), 7'b1_0_1_0_0_1_0);
    check("hold2_cur", cur_div, 8'd9);

    // Async reset mid-DRAIN
    send(8'd3);
    step(1);
    #2 reset = 1'b1;
    #1;
    check("arst_flags", flags(), 7'b0);
    check("arst_div_n", div_n, 8'd0);
    check("arst_cur", cur_div, 8'd0);
    step(1);
    reset = 1'b0;
    step(1);
    check("arst_rel_ready", req_ready, 1'b1);

    // Max value
    send(8'd255);
    step(4);
    check("r255_load_div_n", div_n, 8'd255);
    check("r255_load_rst", div_rst, 1'b1);
    step(1);
    check("r255_run_flags", flags(), 7'b1_0_1_0_0_1_0);
    check("r255_cur", cur_div, 8'd255);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
